// File: rtl/mem_arbiter2_pkg.sv
// Shared constants for the two-master SRAM port arbiter: master indices and the
// layout of the 2-bit tag carried on the controller's mem_id / mem_readdataid.
package mem_arbiter2_pkg;

  localparam int unsigned N_MASTERS        = 2;
  localparam int unsigned M_CPU            = 0;
  localparam int unsigned M_DMA            = 1;
  localparam int unsigned MEMID_MASTER_BIT = 1;
  localparam int unsigned MEMID_TAG_BIT    = 0;

  typedef logic [1:0] mem_id_t;

  function automatic mem_id_t make_mem_id(input logic master, input logic tag);
    mem_id_t id;
    id                   = '0;
    id[MEMID_MASTER_BIT] = master;
    id[MEMID_TAG_BIT]    = tag;
    return id;
  endfunction

endpackage

// File: rtl/mem_arbiter2_outst.sv
// Per-master count of reads in flight: up on an accepted read, down on a return,
// saturating at zero; 'full' throttles further reads from that master.
module mem_arb_outst_ctr #(
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == MAX_OUTST[CNT_W-1:0]);

  // A return for a master with nothing in flight means the controller is out of step.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(dec_i && !inc_i && count_q == '0));

endmodule

// File: rtl/mem_arbiter2.sv
// Round-robin arbiter letting the CPU (master 0) and a DMA/video engine (master 1)
// share one pipelined SRAM controller port; read returns are routed by the mem_id tag.
module mem_arbiter2
  import mem_arbiter2_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned M1_PRIO   = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  output logic        m0_waitrequest_o,
  input  logic        m0_id_i,
  input  logic [29:0] m0_address_i,
  input  logic        m0_read_i,
  input  logic        m0_write_i,
  input  logic [31:0] m0_writedata_i,
  input  logic [3:0]  m0_writedatamask_i,
  output logic [31:0] m0_readdata_o,
  output logic        m0_readdatavalid_o,
  output logic        m0_readdataid_o,

  output logic        m1_waitrequest_o,
  input  logic        m1_id_i,
  input  logic [29:0] m1_address_i,
  input  logic        m1_read_i,
  input  logic        m1_write_i,
  input  logic [31:0] m1_writedata_i,
  input  logic [3:0]  m1_writedatamask_i,
  output logic [31:0] m1_readdata_o,
  output logic        m1_readdatavalid_o,
  output logic        m1_readdataid_o,

  input  logic        mem_waitrequest_i,
  output logic [1:0]  mem_id_o,
  output logic [29:0] mem_address_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_writedata_o,
  output logic [3:0]  mem_writedatamask_o,
  input  logic [31:0] mem_readdata_i,
  input  logic        mem_readdatavalid_i,
  input  logic [1:0]  mem_readdataid_i
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  logic        rd     [N_MASTERS];
  logic        wr     [N_MASTERS];
  logic        tag    [N_MASTERS];
  logic [29:0] addr   [N_MASTERS];
  logic [31:0] wdata  [N_MASTERS];
  logic [3:0]  wmask  [N_MASTERS];
  logic [CNT_W-1:0] outst [N_MASTERS];

  logic [N_MASTERS-1:0] full;
  logic [N_MASTERS-1:0] eligible;
  logic [N_MASTERS-1:0] inc;
  logic [N_MASTERS-1:0] dec;
  logic [N_MASTERS-1:0] wait_v;
  logic [N_MASTERS-1:0] rdv_v;

  logic grant_q, grant_d;
  logic lock_q,  lock_d;
  logic last_q,  last_d;
  logic grant_c;
  logic gnt_valid;
  logic accept;

  assign rd[M_CPU]    = m0_read_i;
  assign wr[M_CPU]    = m0_write_i;
  assign tag[M_CPU]   = m0_id_i;
  assign addr[M_CPU]  = m0_address_i;
  assign wdata[M_CPU] = m0_writedata_i;
  assign wmask[M_CPU] = m0_writedatamask_i;
  assign rd[M_DMA]    = m1_read_i;
  assign wr[M_DMA]    = m1_write_i;
  assign tag[M_DMA]   = m1_id_i;
  assign addr[M_DMA]  = m1_address_i;
  assign wdata[M_DMA] = m1_writedata_i;
  assign wmask[M_DMA] = m1_writedatamask_i;

  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : gen_master
      // A master at its read limit still gets its writes through.
      assign eligible[gi] = wr[gi] | (rd[gi] & ~full[gi]);
      assign inc[gi]      = accept & rd[grant_c] & (grant_c == 1'(gi));
      assign dec[gi]      = mem_readdatavalid_i & (mem_readdataid_i[MEMID_MASTER_BIT] == 1'(gi));
      assign wait_v[gi]   = ~(gnt_valid & (grant_c == 1'(gi))) | mem_waitrequest_i;
      assign rdv_v[gi]    = rst_ni & dec[gi];

      mem_arb_outst_ctr #(
        .MAX_OUTST (MAX_OUTST),
        .CNT_W     (CNT_W)
      ) u_ctr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (inc[gi]),
        .dec_i   (dec[gi]),
        .count_o (outst[gi]),
        .full_o  (full[gi])
      );
    end
  endgenerate

  always_comb begin
    grant_c = grant_q;
    if (!lock_q) begin
      if (eligible[M_CPU] && eligible[M_DMA]) begin
        grant_c = (M1_PRIO != 0) ? 1'b1 : ~last_q;
      end else if (eligible[M_DMA]) begin
        grant_c = 1'b1;
      end else if (eligible[M_CPU]) begin
        grant_c = 1'b0;
      end
    end
  end

  // Outputs are forced idle while rst_n is low, independent of the clock.
  assign gnt_valid = rst_ni & eligible[grant_c];
  assign accept    = gnt_valid & ~mem_waitrequest_i;

  always_comb begin
    grant_d = grant_q;
    lock_d  = lock_q;
    last_d  = last_q;
    if (gnt_valid) begin
      grant_d = grant_c;
      lock_d  = mem_waitrequest_i;
      if (!mem_waitrequest_i) begin
        last_d = grant_c;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q <= 1'b0;
      lock_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      grant_q <= grant_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
    end
  end

  assign mem_read_o          = gnt_valid & rd[grant_c];
  assign mem_write_o         = gnt_valid & wr[grant_c];
  assign mem_id_o            = make_mem_id(grant_c, tag[grant_c]);
  assign mem_address_o       = addr[grant_c];
  assign mem_writedata_o     = wdata[grant_c];
  assign mem_writedatamask_o = wmask[grant_c];

  assign m0_waitrequest_o   = wait_v[M_CPU];
  assign m1_waitrequest_o   = wait_v[M_DMA];
  assign m0_readdatavalid_o = rdv_v[M_CPU];
  assign m1_readdatavalid_o = rdv_v[M_DMA];
  assign m0_readdataid_o    = mem_readdataid_i[MEMID_TAG_BIT];
  assign m1_readdataid_o    = mem_readdataid_i[MEMID_TAG_BIT];
  assign m0_readdata_o      = mem_readdata_i;
  assign m1_readdata_o      = mem_readdata_i;

endmodule

// File: tb/tb_mem_arbiter2.sv
// Scenario bench for mem_arbiter2: expected grants and read returns are queued as
// stimulus is driven and checked when the arbiter drives the memory or return side.
module tb_mem_arbiter2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        rd [2], wr [2], idb [2];
  logic [29:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  wmask [2];
  logic        mem_wait, mem_rdv;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rdid;

  logic        m_wait [2], m_rdv [2], m_rdid [2];
  logic [31:0] m_rdata [2];
  logic [1:0]  mem_id;
  logic [29:0] mem_addr;
  logic        mem_read, mem_write;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;

  logic        p_wait [2], p_rdv [2], p_rdid [2];
  logic [31:0] p_rdata [2];
  logic [1:0]  p_id;
  logic [29:0] p_addr;
  logic        p_read, p_write;
  logic [31:0] p_wdata;
  logic [3:0]  p_wmask;

  int n_cmp = 0;
  int n_bad = 0;
  logic       exp_gnt [$];
  logic [1:0] ret_q [$];

  mem_arbiter2 #(.MAX_OUTST(4), .M1_PRIO(0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_waitrequest_o(m_wait[0]), .m0_id_i(idb[0]), .m0_address_i(addr[0]),
    .m0_read_i(rd[0]), .m0_write_i(wr[0]), .m0_writedata_i(wdata[0]),
    .m0_writedatamask_i(wmask[0]), .m0_readdata_o(m_rdata[0]),
    .m0_readdatavalid_o(m_rdv[0]), .m0_readdataid_o(m_rdid[0]),
    .m1_waitrequest_o(m_wait[1]), .m1_id_i(idb[1]), .m1_address_i(addr[1]),
    .m1_read_i(rd[1]), .m1_write_i(wr[1]), .m1_writedata_i(wdata[1]),
    .m1_writedatamask_i(wmask[1]), .m1_readdata_o(m_rdata[1]),
    .m1_readdatavalid_o(m_rdv[1]), .m1_readdataid_o(m_rdid[1]),
    .mem_waitrequest_i(mem_wait), .mem_id_o(mem_id), .mem_address_o(mem_addr),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_writedata_o(mem_wdata),
    .mem_writedatamask_o(mem_wmask), .mem_readdata_i(mem_rdata),
    .mem_readdatavalid_i(mem_rdv), .mem_readdataid_i(mem_rdid)
  );

  // Fixed-priority variant; never stalled and never given returns.
  mem_arbiter2 #(.MAX_OUTST(4), .M1_PRIO(1)) dut_p (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_waitrequest_o(p_wait[0]), .m0_id_i(idb[0]), .m0_address_i(addr[0]),
    .m0_read_i(rd[0]), .m0_write_i(wr[0]), .m0_writedata_i(wdata[0]),
    .m0_writedatamask_i(wmask[0]), .m0_readdata_o(p_rdata[0]),
    .m0_readdatavalid_o(p_rdv[0]), .m0_readdataid_o(p_rdid[0]),
    .m1_waitrequest_o(p_wait[1]), .m1_id_i(idb[1]), .m1_address_i(addr[1]),
    .m1_read_i(rd[1]), .m1_write_i(wr[1]), .m1_writedata_i(wdata[1]),
    .m1_writedatamask_i(wmask[1]), .m1_readdata_o(p_rdata[1]),
    .m1_readdatavalid_o(p_rdv[1]), .m1_readdataid_o(p_rdid[1]),
    .mem_waitrequest_i(1'b0), .mem_id_o(p_id), .mem_address_o(p_addr),
    .mem_read_o(p_read), .mem_write_o(p_write), .mem_writedata_o(p_wdata),
    .mem_writedatamask_o(p_wmask), .mem_readdata_i(32'h0),
    .mem_readdatavalid_i(1'b0), .mem_readdataid_i(2'b00)
  );

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; idb[i] = 1'b0;
      addr[i] = 30'h0; wdata[i] = 32'h0; wmask[i] = 4'h0;
    end
    mem_wait = 1'b0; mem_rdv = 1'b0; mem_rdata = 32'h0; mem_rdid = 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    ret_q.delete();
    exp_gnt.delete();
  endtask

  // Controller model: returns every queued read in order and checks the routing.
  task automatic drain(input string name);
    logic [1:0]  r;
    logic [31:0] d;
    int          own, other;
    while (ret_q.size() > 0) begin
      r = ret_q.pop_front();
      d = $urandom;
      own = r[1] ? 1 : 0;
      other = 1 - own;
      mem_rdv = 1'b1; mem_rdid = r; mem_rdata = d;
      @(negedge clk);
      n_cmp++; if (m_rdv[own] !== 1'b1) begin n_bad++; $display("FAIL %s rdv m%0d got %b want 1", name, own, m_rdv[own]); end
      n_cmp++; if (m_rdv[other] !== 1'b0) begin n_bad++; $display("FAIL %s rdv m%0d got %b want 0", name, other, m_rdv[other]); end
      n_cmp++; if (m_rdid[own] !== r[0]) begin n_bad++; $display("FAIL %s rdid m%0d got %b want %b", name, own, m_rdid[own], r[0]); end
      n_cmp++; if (m_rdata[own] !== d) begin n_bad++; $display("FAIL %s rdata m%0d got %h want %h", name, own, m_rdata[own], d); end
      $display("return id=%b data=%h rdv0=%b rdv1=%b", r, d, m_rdv[0], m_rdv[1]);
      tick();
      mem_rdv = 1'b0;
    end
    n_cmp++; if (dut.outst[0] !== 3'd0) begin n_bad++; $display("FAIL %s outst0 got %0d want 0", name, dut.outst[0]); end
    n_cmp++; if (dut.outst[1] !== 3'd0) begin n_bad++; $display("FAIL %s outst1 got %0d want 0", name, dut.outst[1]); end
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    rd[0] = 1'b1; mem_rdv = 1'b1; mem_rdid = 2'b00;
    #1;
    n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL reset mem_read got %b want 0", mem_read); end
    n_cmp++; if (m_wait[0] !== 1'b1 || m_wait[1] !== 1'b1) begin n_bad++; $display("FAIL reset waitreq got %b%b want 11", m_wait[1], m_wait[0]); end
    n_cmp++; if (m_rdv[0] !== 1'b0) begin n_bad++; $display("FAIL reset rdv0 got %b want 0", m_rdv[0]); end
    tick();
    n_cmp++; if (dut.outst[0] !== 3'd0) begin n_bad++; $display("FAIL reset outst0 got %0d want 0", dut.outst[0]); end
    $display("reset: mem_read=%b wait=%b%b", mem_read, m_wait[1], m_wait[0]);
    idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    rd[0] = 1'b1; addr[0] = 30'h100; idb[0] = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL single mem_read got %b want 1", mem_read); end
    n_cmp++; if (mem_id !== 2'b00) begin n_bad++; $display("FAIL single mem_id got %b want 00", mem_id); end
    n_cmp++; if (mem_addr !== 30'h100) begin n_bad++; $display("FAIL single addr got %h want 100", mem_addr); end
    n_cmp++; if (m_wait[0] !== 1'b0 || m_wait[1] !== 1'b1) begin n_bad++; $display("FAIL single waitreq got %b%b want 10", m_wait[1], m_wait[0]); end
    $display("single read: mem_read=%b id=%b addr=%h", mem_read, mem_id, mem_addr);
    ret_q.push_back(2'b00);
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL single idle mem_read got %b want 0", mem_read); end
    tick();
    drain("single");
  endtask

  task automatic test_round_robin();
    logic g;
    do_reset();
    rd[0] = 1'b1; rd[1] = 1'b1; idb[0] = 1'b1; idb[1] = 1'b0;
    addr[0] = 30'h200; addr[1] = 30'h300;
    for (int i = 0; i < 4; i++) exp_gnt.push_back(i[0]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      g = exp_gnt.pop_front();
      n_cmp++; if (mem_read !== 1'b1 || mem_id !== {g, ~g}) begin n_bad++; $display("FAIL rr cycle %0d read=%b id=%b want 1 %b", i, mem_read, mem_id, {g, ~g}); end
      n_cmp++; if (p_read !== 1'b1 || p_id[1] !== 1'b1) begin n_bad++; $display("FAIL prio cycle %0d read=%b grant=%b want 1 1", i, p_read, p_id[1]); end
      $display("rr cycle %0d grant=%b prio_grant=%b", i, mem_id[1], p_id[1]);
      ret_q.push_back({g, ~g});
      tick();
    end
    idle();
    drain("rr");
  endtask

  // Row: {r0, w0, r1, ws, grant, exp_read, exp_write, exp_wait0, exp_wait1}
  localparam logic [8:0] LOCK_TBL [10] = '{
    9'b101001001, 9'b101111011, 9'b101111011, 9'b101111011, 9'b101011010,
    9'b101001001, 9'b010100111, 9'b011100111, 9'b011000101, 9'b001011010
  };

  task automatic test_lock();
    logic [8:0] row;
    do_reset();
    idb[0] = 1'b0; idb[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      row = LOCK_TBL[c];
      rd[0] = row[8]; wr[0] = row[7]; rd[1] = row[6]; mem_wait = row[5];
      @(negedge clk);
      n_cmp++; if (mem_read !== row[3] || mem_write !== row[2]) begin n_bad++; $display("FAIL lock c%0d rd/wr got %b%b want %b%b", c, mem_read, mem_write, row[3], row[2]); end
      n_cmp++; if (mem_id[1] !== row[4]) begin n_bad++; $display("FAIL lock c%0d grant got %b want %b", c, mem_id[1], row[4]); end
      n_cmp++; if (m_wait[0] !== row[1] || m_wait[1] !== row[0]) begin n_bad++; $display("FAIL lock c%0d wait got %b%b want %b%b", c, m_wait[1], m_wait[0], row[0], row[1]); end
      $display("lock c%0d grant=%b read=%b write=%b wait=%b%b", c, mem_id[1], mem_read, mem_write, m_wait[1], m_wait[0]);
      if (row[3] && !row[5]) ret_q.push_back({row[4], row[4]});
      tick();
    end
    idle();
    drain("lock");
  endtask

  task automatic test_throttle();
    logic [31:0] d;
    do_reset();
    rd[0] = 1'b1; idb[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr[0] = 30'h400 + 30'(i);
      @(negedge clk);
      n_cmp++; if (mem_read !== 1'b1 || m_wait[0] !== 1'b0) begin n_bad++; $display("FAIL thr read %0d got read=%b wait=%b", i, mem_read, m_wait[0]); end
      ret_q.push_back(2'b00);
      tick();
    end
    @(negedge clk);
    n_cmp++; if (m_wait[0] !== 1'b1 || mem_read !== 1'b0) begin n_bad++; $display("FAIL thr held got wait=%b read=%b want 1 0", m_wait[0], mem_read); end
    n_cmp++; if (dut.outst[0] !== 3'd4) begin n_bad++; $display("FAIL thr outst got %0d want 4", dut.outst[0]); end
    $display("throttle: 5th read wait=%b outst=%0d", m_wait[0], dut.outst[0]);
    tick();
    rd[0] = 1'b0; wr[0] = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_write !== 1'b1 || m_wait[0] !== 1'b0) begin n_bad++; $display("FAIL thr write got write=%b wait=%b want 1 0", mem_write, m_wait[0]); end
    tick();
    wr[0] = 1'b0; rd[0] = 1'b1;
    d = $urandom;
    mem_rdv = 1'b1; mem_rdid = ret_q.pop_front(); mem_rdata = d;
    @(negedge clk);
    n_cmp++; if (m_wait[0] !== 1'b1 || m_rdv[0] !== 1'b1) begin n_bad++; $display("FAIL thr return got wait=%b rdv=%b want 1 1", m_wait[0], m_rdv[0]); end
    tick();
    mem_rdv = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_wait[0] !== 1'b0 || mem_read !== 1'b1) begin n_bad++; $display("FAIL thr 5th got wait=%b read=%b want 0 1", m_wait[0], mem_read); end
    $display("throttle: 5th read accepted wait=%b", m_wait[0]);
    ret_q.push_back(2'b00);
    tick();
    idle();
    n_cmp++; if (dut.outst[0] !== 3'd4) begin n_bad++; $display("FAIL thr end outst got %0d want 4", dut.outst[0]); end
    drain("throttle");
  endtask

  task automatic test_same_cycle();
    do_reset();
    rd[1] = 1'b1; idb[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ret_q.push_back(2'b11);
      tick();
    end
    n_cmp++; if (dut.outst[1] !== 3'd2) begin n_bad++; $display("FAIL same pre outst1 got %0d want 2", dut.outst[1]); end
    mem_rdv = 1'b1; mem_rdid = ret_q.pop_front(); mem_rdata = 32'h1234_5678;
    @(negedge clk);
    n_cmp++; if (m_rdv[1] !== 1'b1 || m_wait[1] !== 1'b0) begin n_bad++; $display("FAIL same strobe got rdv=%b wait=%b want 1 0", m_rdv[1], m_wait[1]); end
    ret_q.push_back(2'b11);
    tick();
    idle();
    n_cmp++; if (dut.outst[1] !== 3'd2) begin n_bad++; $display("FAIL same post outst1 got %0d want 2", dut.outst[1]); end
    $display("same cycle accept+return: outst1=%0d", dut.outst[1]);
    drain("same");
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    rd[1] = 1'b1; idb[1] = 1'b0;
    tick();
    mem_wait = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL midrst mem_read got %b want 0", mem_read); end
    n_cmp++; if (m_wait[0] !== 1'b1 || m_wait[1] !== 1'b1) begin n_bad++; $display("FAIL midrst wait got %b%b want 11", m_wait[1], m_wait[0]); end
    n_cmp++; if (dut.outst[1] !== 3'd0) begin n_bad++; $display("FAIL midrst outst1 got %0d want 0", dut.outst[1]); end
    $display("reset mid-lock: read=%b wait=%b%b outst1=%0d", mem_read, m_wait[1], m_wait[0], dut.outst[1]);
    tick();
    rst_n = 1'b1;
    ret_q.delete();
    mem_wait = 1'b0; rd[0] = 1'b1; rd[1] = 1'b1; idb[0] = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_id !== 2'b01 || mem_read !== 1'b1) begin n_bad++; $display("FAIL midrst first grant got id=%b read=%b want 01 1", mem_id, mem_read); end
    ret_q.push_back(2'b01);
    tick();
    idle();
    drain("midrst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n = 1'b1;
    #2;
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_throttle();
    test_same_cycle();
    test_reset_mid_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
